xrisc_store_checker: RTL

Synthesizable, parametrised store-sequence checker for XRISC core benches and FPGA bring-up. It replaces a single hard-coded "address X, data Y" success check.
- Loaded with up to DEPTH expected (address, data) stores, then armed.
- Watches the core's data-memory write port and declares PASS, or FAIL with a cause code: mismatch, timeout, or empty table.
- Instantiated beside the top module; taps MemWrite/DataAdr/WriteData.

---
 rtl/xrisc_store_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/xrisc_store_checker.sv
// Store-sequence checker for XRISC benches and bring-up.
// A table of expected (address, data) stores is loaded while idle, then the
// checker is armed and follows the core's data-memory write port in order,
// ending in a sticky PASS or FAIL (mismatch, timeout or empty table).
module xrisc_store_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         exp_we,
    input  logic [ADDR_W-1:0]            exp_addr,
    input  logic [DATA_W-1:0]            exp_data,
    output logic                         exp_full,
    input  logic                         start,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            data_adr,
    input  logic [DATA_W-1:0]            write_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
    output logic [ADDR_W-1:0]            err_adr,
    output logic [DATA_W-1:0]            err_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       wp, wp_nxt;
    logic [CW-1:0]       rp, rp_nxt;
    logic [TW-1:0]       timer, timer_nxt;
    logic [CW-1:0]       match_cnt_nxt;
    logic [1:0]          fail_code_nxt;
    logic [ADDR_W-1:0]   err_adr_nxt;
    logic [DATA_W-1:0]   err_data_nxt;
    logic                load_ok;
    logic [ADDR_W-1:0]   ent_adr;
    logic [DATA_W-1:0]   ent_dat;

    // Expected-store table; contents are don't-care after reset.
    logic [ADDR_W-1:0]   tbl_adr [DEPTH];
    logic [DATA_W-1:0]   tbl_dat [DEPTH];

    assign ent_adr = tbl_adr[rp[IW-1:0]];
    assign ent_dat = tbl_dat[rp[IW-1:0]];

    // Next-state and counter logic; clear overrides everything else.
    always_comb begin
        state_nxt     = state;
        wp_nxt        = wp;
        rp_nxt        = rp;
        timer_nxt     = timer;
        match_cnt_nxt = match_cnt;
        fail_code_nxt = fail_code;
        err_adr_nxt   = err_adr;
        err_data_nxt  = err_data;
        load_ok       = 1'b0;

        if (clear) begin
            state_nxt     = ST_IDLE;
            wp_nxt        = '0;
            rp_nxt        = '0;
            timer_nxt     = '0;
            match_cnt_nxt = '0;
            fail_code_nxt = 2'd0;
            err_adr_nxt   = '0;
            err_data_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    load_ok = exp_we && (wp != CW'(DEPTH));
                    if (load_ok) wp_nxt = wp + CW'(1);
                    // A write in the same cycle as start is already counted.
                    if (start) begin
                        if (wp_nxt == '0) begin
                            state_nxt     = ST_FAIL;
                            fail_code_nxt = 2'd3;
                        end else begin
                            state_nxt     = ST_RUN;
                            rp_nxt        = '0;
                            timer_nxt     = '0;
                            match_cnt_nxt = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (mem_write && data_adr == ent_adr && write_data == ent_dat) begin
                        // A match beats a same-cycle timeout.
                        rp_nxt        = rp + CW'(1);
                        match_cnt_nxt = match_cnt + CW'(1);
                        timer_nxt     = '0;
                        if (rp + CW'(1) == wp) state_nxt = ST_PASS;
                    end else if (mem_write && (STRICT != 0 || data_adr == ent_adr)) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = 2'd1;
                        err_adr_nxt   = data_adr;
                        err_data_nxt  = write_data;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = 2'd2;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: ; // PASS and FAIL hold until clear
            endcase
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wp        <= '0;
            rp        <= '0;
            timer     <= '0;
            match_cnt <= '0;
            fail_code <= 2'd0;
            err_adr   <= '0;
            err_data  <= '0;
        end else begin
            state     <= state_nxt;
            wp        <= wp_nxt;
            rp        <= rp_nxt;
            timer     <= timer_nxt;
            match_cnt <= match_cnt_nxt;
            fail_code <= fail_code_nxt;
            err_adr   <= err_adr_nxt;
            err_data  <= err_data_nxt;
        end
    end

    // Table load; writes past DEPTH or outside IDLE are dropped by load_ok.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            tbl_adr[wp[IW-1:0]] <= exp_addr;
            tbl_dat[wp[IW-1:0]] <= exp_data;
        end
    end

    assign exp_full = (wp == CW'(DEPTH));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_PASS) || (state == ST_FAIL);
    assign pass     = (state == ST_PASS);

endmodule
